rv_mc_ctrl: RTL and testbench
=============================

Name: rv_mc_ctrl

Overview:
- Multi-cycle main controller for the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared single-ALU datapath.
- Handshakes with instruction and data memory.
- Drives the immediate-type select, mux selects and write enables for PC, IR and the register file.
- Sits between the IR/ALU datapath and the memory interfaces. It is the only owner of datapath write enables.

Parameters:
- MEM_TIMEOUT, 0, max wait cycles for imem_ack/dmem_ack before trapping; 0 disables the timeout.
- TIMEOUT_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2**TIMEOUT_W.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- inst_code  in  32  IR contents; valid from DECODE onward
- imem_ack  in  1  instruction read done; IR data valid this cycle
- dmem_ack  in  1  data access done
- branch_taken  in  1  ALU comparator result; valid in EXEC
- imem_req  out  1  instruction fetch request
- ir_we  out  1  IR load strobe
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- reg_we  out  1  register file write enable
- pc_we  out  1  PC write enable
- pc_sel  out  2  PC source: 0 = pc+4, 1 = pc+imm, 2 = (rs1+imm)&~1
- alu_src_a  out  2  ALU operand A: 0 = rs1, 1 = pc, 2 = zero
- alu_src_b  out  1  ALU operand B: 0 = rs2, 1 = imm
- wb_sel  out  2  writeback source: 0 = ALU, 1 = mem, 2 = pc+4
- imm_type  out  3  immediate type: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J
- state_o  out  3  current state encoding
- halted  out  1  sticky trap indicator
- trap_cause  out  2  0 none, 1 illegal opcode, 2 memory timeout

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
- Outputs are Moore decodes of the state plus the opcode class latched in DECODE, with one exception: ir_we is combinational on imem_ack.
- Reset (async, any cycle, including mid-handshake):
  - state = FETCH, wait counter = 0, halted = 0, trap_cause = 0, latched class cleared.
  - All enables and requests are low during reset; imem_req rises in the first cycle after release.
- FETCH:
  - imem_req = 1 until imem_ack is sampled high.
  - ir_we = imem_ack.
  - On ack, go to DECODE.
- DECODE:
  - Classify inst_code[6:0] into LOAD, OPIMM, OP, STORE, BRANCH, JAL, JALR, LUI or AUIPC; latch the class; drive imm_type.
  - Any other opcode goes to TRAP with cause 1; otherwise go to EXEC.
- EXEC: alu_src and imm_type per class.
  - LOAD/STORE → MEM.
  - All other classes → WB.
  - BRANCH samples branch_taken into a register.
- MEM:
  - dmem_req = 1, held until dmem_ack; dmem_we = (class == STORE).
  - LOAD on ack → WB.
  - STORE on ack: pc_we = 1, pc_sel = 0, then → FETCH.
- WB: exactly one cycle, pc_we = 1, then → FETCH.
  - reg_we = 1 for every class except BRANCH.
  - wb_sel = 2 for JAL/JALR, 1 for LOAD, 0 otherwise.
  - pc_sel = 1 for JAL or a taken branch, 2 for JALR, 0 otherwise.
- imm_type values: 0 in FETCH; I for LOAD/OPIMM/JALR, S for STORE, B for BRANCH, U for LUI/AUIPC, J for JAL.
- Minimum latency with zero-wait ack:
  - OP/OPIMM/LUI/AUIPC/JAL/JALR/BRANCH: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Counts consecutive cycles in FETCH or MEM with no ack; clears on ack or state change.
  - If MEM_TIMEOUT ≠ 0 and the count reaches MEM_TIMEOUT, go to TRAP with cause 2 (request dropped).
  - The counter saturates; it never wraps.
- TRAP:
  - halted = 1; all enables and requests are 0.
  - Stays in TRAP until reset.
- Ack while the matching request is low is ignored. An ack in the same cycle as the timeout limit wins; no trap is taken.
- No enable is ever asserted for more than one cycle per instruction, except the requests.

Optional Feature:
- Macro: RV_MC_CTRL_INSTRET_EN.
- Defined:
  - Adds output instret_o [63:0], reset to 0.
  - Increments by 1 on each retirement: the WB cycle, or the STORE ack cycle in MEM.
  - Wraps modulo 2^64; never increments in TRAP.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package rv_ctrl_pkg holds:
  - state_t enum (3 bits, encodings above);
  - imm_type_t and opclass_t enums;
  - RV32I opcode localparams;
  - pc_sel, alu_src and wb_sel encoding constants.
- Sub-module rv_opcode_dec: purely combinational inst_code[6:0] → {opclass, imm_type, legal}. It is reused by the immediate generator's owners.

Test Plan:
- ADDI 0x00500093, immediate acks:
  - states 0→1→2→4→0 in 4 cycles;
  - imm_type = 1, alu_src_b = 1;
  - reg_we and pc_we high only in WB, with pc_sel = 0.
- LW 0x0000A103, dmem_ack delayed 3 cycles:
  - dmem_req held high for 4 cycles, dmem_we = 0;
  - WB has wb_sel = 1; total 8 cycles.
- SW 0x0020A023:
  - MEM asserts dmem_we = 1 and pc_we on the ack cycle;
  - reg_we is never asserted; returns to FETCH.
- BEQ 0x00208463:
  - branch_taken = 1 gives WB pc_sel = 1, reg_we = 0;
  - repeated with branch_taken = 0 gives pc_sel = 0.
- Opcode 0x0000007F:
  - DECODE → TRAP; halted = 1, trap_cause = 1;
  - imem_req stays 0 for 20 cycles; reset returns to FETCH.
- MEM_TIMEOUT = 4, imem_ack held 0:
  - TRAP with cause 2 after 4 wait cycles;
  - separately, async reset asserted mid-MEM gives dmem_req = 0 immediately.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller:
// states, opcode classes, immediate types and datapath select codes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_t;

  typedef enum logic [3:0] {
    CL_NONE   = 4'd0,
    CL_LOAD   = 4'd1,
    CL_OPIMM  = 4'd2,
    CL_OP     = 4'd3,
    CL_STORE  = 4'd4,
    CL_BRANCH = 4'd5,
    CL_JAL    = 4'd6,
    CL_JALR   = 4'd7,
    CL_LUI    = 4'd8,
    CL_AUIPC  = 4'd9
  } opclass_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_REL    = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic       SRCB_RS2  = 1'b0;
  localparam logic       SRCB_IMM  = 1'b1;

  localparam logic [1:0] WB_ALU    = 2'd0;
  localparam logic [1:0] WB_MEM    = 2'd1;
  localparam logic [1:0] WB_PC4    = 2'd2;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  function automatic imm_type_t class_imm(input opclass_t c);
    case (c)
      CL_LOAD, CL_OPIMM, CL_JALR: class_imm = IMM_I;
      CL_STORE:                   class_imm = IMM_S;
      CL_BRANCH:                  class_imm = IMM_B;
      CL_LUI, CL_AUIPC:           class_imm = IMM_U;
      CL_JAL:                     class_imm = IMM_J;
      default:                    class_imm = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rv_opcode_dec.sv
// Combinational RV32I major-opcode classifier: opcode -> class, immediate type, legal.
module rv_opcode_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_t   opclass,
  output imm_type_t  imm_type,
  output logic       legal
);

  always_comb begin
    opclass = CL_NONE;
    legal   = 1'b1;
    case (opcode)
      OPC_LOAD:   opclass = CL_LOAD;
      OPC_OPIMM:  opclass = CL_OPIMM;
      OPC_OP:     opclass = CL_OP;
      OPC_STORE:  opclass = CL_STORE;
      OPC_BRANCH: opclass = CL_BRANCH;
      OPC_JAL:    opclass = CL_JAL;
      OPC_JALR:   opclass = CL_JALR;
      OPC_LUI:    opclass = CL_LUI;
      OPC_AUIPC:  opclass = CL_AUIPC;
      default:    legal   = 1'b0;
    endcase
    imm_type = class_imm(opclass);
  end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I main controller (FETCH/DECODE/EXEC/MEM/WB/TRAP).
// Define RV_MC_CTRL_INSTRET_EN to add the 64-bit retired-instruction counter instret_o.
module rv_mc_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 0,
  parameter int TIMEOUT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst_code,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  wb_sel,
  output logic [2:0]  imm_type,
  output logic [2:0]  state_o,
  output logic        halted,
  output logic [1:0]  trap_cause
`ifdef RV_MC_CTRL_INSTRET_EN
  ,
  output logic [63:0] instret_o
`endif
);

  localparam logic [TIMEOUT_W:0] TIMEOUT_LIMIT = (TIMEOUT_W + 1)'(MEM_TIMEOUT);

  state_t               state, state_next;
  opclass_t             cls_q, dec_class;
  imm_type_t            dec_imm;
  logic                 dec_legal;
  logic                 taken_q;
  logic [1:0]           cause_q, cause_next;
  logic [TIMEOUT_W-1:0] wait_cnt, wait_next, wait_inc;
  logic [TIMEOUT_W:0]   cnt_plus;
  logic                 cur_ack, waiting, timeout_hit;
  logic                 imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, pc_we_c;

  wire unused_inst_bits = ^inst_code[31:7];

  rv_opcode_dec u_dec (
    .opcode   (inst_code[6:0]),
    .opclass  (dec_class),
    .imm_type (dec_imm),
    .legal    (dec_legal)
  );

  // Only the ack matching the request of the current state counts.
  assign cur_ack     = (state == ST_FETCH) ? imem_ack : ((state == ST_MEM) ? dmem_ack : 1'b0);
  assign waiting     = ((state == ST_FETCH) || (state == ST_MEM)) && !cur_ack;
  assign cnt_plus    = {1'b0, wait_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign wait_inc    = cnt_plus[TIMEOUT_W] ? wait_cnt : cnt_plus[TIMEOUT_W-1:0];
  assign timeout_hit = (MEM_TIMEOUT != 0) && waiting && (cnt_plus >= TIMEOUT_LIMIT);
  assign wait_next   = (waiting && (state_next == state)) ? wait_inc : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cls_q    <= CL_NONE;
      taken_q  <= 1'b0;
      cause_q  <= TRAP_NONE;
      wait_cnt <= '0;
    end else begin
      if (state == ST_DECODE) cls_q <= dec_class;
      if (state == ST_EXEC)   taken_q <= (cls_q == CL_BRANCH) && branch_taken;
      cause_q  <= cause_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    cause_next = cause_q;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    pc_sel     = PC_PLUS4;
    alu_src_a  = SRCA_RS1;
    alu_src_b  = SRCB_RS2;
    wb_sel     = WB_ALU;
    imm_type   = IMM_NONE;
    case (state)
      ST_FETCH: begin
        imem_req_c = 1'b1;
        ir_we_c    = imem_ack;
        if (imem_ack) state_next = ST_DECODE;
        else if (timeout_hit) begin
          state_next = ST_TRAP;
          cause_next = TRAP_TIMEOUT;
        end
      end
      ST_DECODE: begin
        imm_type = dec_imm;
        if (dec_legal) state_next = ST_EXEC;
        else begin
          state_next = ST_TRAP;
          cause_next = TRAP_ILLEGAL;
        end
      end
      ST_EXEC: begin
        imm_type = class_imm(cls_q);
        case (cls_q)
          CL_JAL, CL_AUIPC: begin alu_src_a = SRCA_PC;   alu_src_b = SRCB_IMM; end
          CL_LUI:           begin alu_src_a = SRCA_ZERO; alu_src_b = SRCB_IMM; end
          CL_OP, CL_BRANCH: begin alu_src_a = SRCA_RS1;  alu_src_b = SRCB_RS2; end
          default:          begin alu_src_a = SRCA_RS1;  alu_src_b = SRCB_IMM; end
        endcase
        state_next = ((cls_q == CL_LOAD) || (cls_q == CL_STORE)) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        imm_type   = class_imm(cls_q);
        dmem_req_c = 1'b1;
        dmem_we_c  = (cls_q == CL_STORE);
        if (dmem_ack) begin
          if (cls_q == CL_STORE) begin
            pc_we_c    = 1'b1;
            state_next = ST_FETCH;
          end else begin
            state_next = ST_WB;
          end
        end else if (timeout_hit) begin
          state_next = ST_TRAP;
          cause_next = TRAP_TIMEOUT;
        end
      end
      ST_WB: begin
        imm_type   = class_imm(cls_q);
        pc_we_c    = 1'b1;
        reg_we_c   = (cls_q != CL_BRANCH);
        if ((cls_q == CL_JAL) || (cls_q == CL_JALR)) wb_sel = WB_PC4;
        else if (cls_q == CL_LOAD)                   wb_sel = WB_MEM;
        if (cls_q == CL_JALR)                                      pc_sel = PC_JALR;
        else if ((cls_q == CL_JAL) || (cls_q == CL_BRANCH && taken_q)) pc_sel = PC_REL;
        state_next = ST_FETCH;
      end
      ST_TRAP: state_next = ST_TRAP;
      default: state_next = ST_FETCH;
    endcase
  end

  // Hold every enable low while reset is asserted, even though the state already reads FETCH.
  assign imem_req   = imem_req_c & ~reset;
  assign ir_we      = ir_we_c    & ~reset;
  assign dmem_req   = dmem_req_c & ~reset;
  assign dmem_we    = dmem_we_c  & ~reset;
  assign reg_we     = reg_we_c   & ~reset;
  assign pc_we      = pc_we_c    & ~reset;
  assign state_o    = state;
  assign halted     = (state == ST_TRAP);
  assign trap_cause = cause_q;

`ifdef RV_MC_CTRL_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        instret_q <= 64'd0;
    else if (pc_we_c) instret_q <= instret_q + 64'd1;
  end

  assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Randomized self-checking bench for rv_mc_ctrl against a per-instruction cycle-trace model.
// Build with RV_MC_CTRL_INSTRET_EN defined to also check the retire counter.
module tb_rv_mc_ctrl;

  localparam int C_ILLEGAL = 0, C_LOAD = 1, C_OPIMM = 2, C_OP = 3, C_STORE = 4,
                 C_BRANCH = 5, C_JAL = 6, C_JALR = 7, C_LUI = 8, C_AUIPC = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_code;
  logic        imem_ack, dmem_ack, branch_taken;
  logic        imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, alu_src_b, halted;
  logic [1:0]  pc_sel, alu_src_a, wb_sel, trap_cause;
  logic [2:0]  imm_type, state_o;
`ifdef RV_MC_CTRL_INSTRET_EN
  logic [63:0] instret;
`endif

  int          nChecks = 0;
  int          nFail   = 0;
  logic [63:0] retired = 64'd0;
  logic [6:0]  legalOps [9] = '{7'h03, 7'h13, 7'h33, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

  always #5 clk = ~clk;

  rv_mc_ctrl #(.MEM_TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_code    (inst_code),
    .imem_ack     (imem_ack),
    .dmem_ack     (dmem_ack),
    .branch_taken (branch_taken),
    .imem_req     (imem_req),
    .ir_we        (ir_we),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .reg_we       (reg_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .wb_sel       (wb_sel),
    .imm_type     (imm_type),
    .state_o      (state_o),
    .halted       (halted),
    .trap_cause   (trap_cause)
`ifdef RV_MC_CTRL_INSTRET_EN
    ,
    .instret_o    (instret)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference tables: what each RV32I major opcode means to the controller.
  function automatic int classOf(input logic [6:0] op);
    case (op)
      7'h03: return C_LOAD;
      7'h13: return C_OPIMM;
      7'h33: return C_OP;
      7'h23: return C_STORE;
      7'h63: return C_BRANCH;
      7'h6F: return C_JAL;
      7'h67: return C_JALR;
      7'h37: return C_LUI;
      7'h17: return C_AUIPC;
      default: return C_ILLEGAL;
    endcase
  endfunction

  function automatic logic [2:0] expImm(input int c);
    if (c == C_LOAD || c == C_OPIMM || c == C_JALR) return 3'd1;
    if (c == C_STORE)                               return 3'd2;
    if (c == C_BRANCH)                              return 3'd3;
    if (c == C_LUI || c == C_AUIPC)                 return 3'd4;
    if (c == C_JAL)                                 return 3'd5;
    return 3'd0;
  endfunction

  function automatic logic [1:0] expSrcA(input int c);
    if (c == C_AUIPC) return 2'd1;
    if (c == C_LUI)   return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic expSrcB(input int c);
    return !(c == C_OP || c == C_BRANCH);
  endfunction

  function automatic logic [1:0] expWbSel(input int c);
    if (c == C_JAL || c == C_JALR) return 2'd2;
    if (c == C_LOAD)               return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] expPcSel(input int c, input logic tk);
    if (c == C_JALR)                      return 2'd2;
    if (c == C_JAL || (c == C_BRANCH && tk)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [9:0] expCtl(input logic [2:0] st, input logic ireq, input logic irwe,
                                        input logic dreq, input logic dwe, input logic rwe,
                                        input logic pwe, input logic hlt);
    return {st, ireq, irwe, dreq, dwe, rwe, pwe, hlt};
  endfunction

  function automatic logic [9:0] obsCtl();
    return {state_o, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, halted};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic drive(input logic ia, input logic da, input logic bt);
    imem_ack = ia;
    dmem_ack = da;
    branch_taken = bt;
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    #1;
    checkOutput("reset_ctl", 64'(obsCtl()), 64'(expCtl(3'd0, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("reset_cause", 64'(trap_cause), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    retired = 64'd0;
`ifdef RV_MC_CTRL_INSTRET_EN
    checkOutput("reset_instret", instret, 64'd0);
`endif
  endtask

  // Walks one instruction cycle by cycle; fdel/mdel are the no-ack cycles before each ack.
  task automatic applyStimulus(input logic [31:0] inst, input int fdel, input int mdel, input logic tk);
    int   c;
    logic st, ld, ack;
    c  = classOf(inst[6:0]);
    st = (c == C_STORE);
    ld = (c == C_LOAD);
    inst_code = inst;
    for (int i = 0; i <= fdel; i++) begin
      drive(i == fdel, rbit(), rbit());
      checkOutput("fetch_ctl", 64'(obsCtl()), 64'(expCtl(3'd0, 1, i == fdel, 0, 0, 0, 0, 0)));
      checkOutput("fetch_imm", 64'(imm_type), 64'd0);
      @(negedge clk);
    end
    drive(rbit(), rbit(), rbit());
    checkOutput("decode_ctl", 64'(obsCtl()), 64'(expCtl(3'd1, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("decode_imm", 64'(imm_type), 64'(expImm(c)));
    @(negedge clk);
    if (c == C_ILLEGAL) return;
    drive(rbit(), rbit(), tk);
    checkOutput("exec_ctl", 64'(obsCtl()), 64'(expCtl(3'd2, 0, 0, 0, 0, 0, 0, 0)));
    checkOutput("exec_imm", 64'(imm_type), 64'(expImm(c)));
    if (c != C_JAL) begin
      checkOutput("exec_src_a", 64'(alu_src_a), 64'(expSrcA(c)));
      checkOutput("exec_src_b", 64'(alu_src_b), 64'(expSrcB(c)));
    end
    @(negedge clk);
    if (st || ld) begin
      for (int i = 0; i <= mdel; i++) begin
        ack = (i == mdel);
        drive(rbit(), ack, rbit());
        checkOutput("mem_ctl", 64'(obsCtl()), 64'(expCtl(3'd3, 0, 0, 1, st, 0, st && ack, 0)));
        if (st && ack) begin
          checkOutput("mem_pc_sel", 64'(pc_sel), 64'd0);
          retired++;
        end
        @(negedge clk);
      end
    end
    if (!st) begin
      drive(rbit(), rbit(), !tk);
      checkOutput("wb_ctl", 64'(obsCtl()), 64'(expCtl(3'd4, 0, 0, 0, 0, c != C_BRANCH, 1, 0)));
      checkOutput("wb_sel", 64'(wb_sel), 64'(expWbSel(c)));
      checkOutput("wb_pc_sel", 64'(pc_sel), 64'(expPcSel(c, tk)));
      retired++;
      @(negedge clk);
    end
`ifdef RV_MC_CTRL_INSTRET_EN
    checkOutput("instret", instret, retired);
`endif
  endtask

  initial begin
    logic [31:0] r;
    int          k;
    reset = 1'b1;
    inst_code = 32'd0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    resetDut();

    $display("[TB] directed instructions");
    applyStimulus(32'h00500093, 0, 0, 1'b0);
    applyStimulus(32'h0000A103, 0, 3, 1'b0);
    applyStimulus(32'h0020A023, 1, 2, 1'b0);
    applyStimulus(32'h00208463, 0, 0, 1'b1);
    applyStimulus(32'h00208463, 0, 0, 1'b0);
    applyStimulus(32'h00500093, 3, 0, 1'b0);

    $display("[TB] randomized instructions");
    repeat (60) begin
      r = $urandom();
      k = $urandom_range(0, 8);
      applyStimulus({r[31:7], legalOps[k]}, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
    end

    $display("[TB] illegal opcode");
    applyStimulus(32'h0000007F, 0, 0, 1'b0);
    checkOutput("illegal_cause", 64'(trap_cause), 64'd1);
    for (int i = 0; i < 20; i++) begin
      drive(rbit(), rbit(), rbit());
      checkOutput("illegal_trap_ctl", 64'(obsCtl()), 64'(expCtl(3'd5, 0, 0, 0, 0, 0, 0, 1)));
      @(negedge clk);
    end
    resetDut();
    drive(1'b0, 1'b0, 1'b0);
    checkOutput("after_reset_ctl", 64'(obsCtl()), 64'(expCtl(3'd0, 1, 0, 0, 0, 0, 0, 0)));
    checkOutput("after_reset_cause", 64'(trap_cause), 64'd0);

    $display("[TB] fetch timeout");
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, rbit(), rbit());
      checkOutput("timeout_wait_ctl", 64'(obsCtl()), 64'(expCtl(3'd0, 1, 0, 0, 0, 0, 0, 0)));
      @(negedge clk);
    end
    drive(rbit(), rbit(), 1'b0);
    checkOutput("timeout_trap_ctl", 64'(obsCtl()), 64'(expCtl(3'd5, 0, 0, 0, 0, 0, 0, 1)));
    checkOutput("timeout_cause", 64'(trap_cause), 64'd2);
    @(negedge clk);
    resetDut();

    $display("[TB] reset during MEM");
    applyStimulus(32'h00500093, 0, 0, 1'b0);
    inst_code = 32'h0000A103;
    drive(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    checkOutput("mid_mem_ctl", 64'(obsCtl()), 64'(expCtl(3'd3, 0, 0, 1, 0, 0, 0, 0)));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_mem_reset_ctl", 64'(obsCtl()), 64'(expCtl(3'd0, 0, 0, 0, 0, 0, 0, 0)));
    @(negedge clk);
    resetDut();
    applyStimulus(32'h0020A023, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
